// File: rtl/gray_window_arbiter_if.sv
// Request/grant bundle between the requesters (master) and the Gray window arbiter (slave).
interface gray_win_if #(
  parameter int NREQ  = 4,
  parameter int CBITS = 11
);
  logic [NREQ-1:0]  req;
  logic [NREQ-1:0]  gnt;
  logic             busy;
  logic [CBITS-1:0] gray_c;
  logic             sig;
  logic             done;

  modport master (output req, input gnt, busy, gray_c, sig, done);
  modport slave  (input req, output gnt, busy, gray_c, sig, done);
endinterface

// File: rtl/gray_window_arbiter.sv
// Round-robin arbiter granting a WIN-cycle Gray-coded counter window to one requester at a time.
// Optional GRAY_WIN_EARLY_RELEASE_EN: the owner dropping its request ends the window early.
module gray_window_arbiter #(
  parameter int NREQ  = 4,
  parameter int CBITS = 11,
  parameter int WIN   = 16
) (
  input  logic      clk,
  input  logic      rst,
  gray_win_if.slave arb
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  state_t           r_state, w_state_nxt;
  logic [CBITS-1:0] r_cnt, w_cnt_nxt;
  logic [NREQ-1:0]  r_gnt, w_gnt_nxt;
  logic [PW-1:0]    r_own, w_own_nxt;
  logic [PW-1:0]    r_ptr, w_ptr_nxt;
  logic [PW-1:0]    w_pick;
  logic             w_found;
  logic             w_last;
  logic             w_rel;
  logic             w_end;

  // Circular search starting one past the previous owner
  always_comb begin
    w_pick  = r_ptr;
    w_found = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      if (!w_found && arb.req[(int'(r_ptr) + k) % NREQ]) begin
        w_found = 1'b1;
        w_pick  = PW'((int'(r_ptr) + k) % NREQ);
      end
    end
  end

  assign w_last = (r_cnt == CBITS'(WIN - 1));

`ifdef GRAY_WIN_EARLY_RELEASE_EN
  assign w_rel = ~arb.req[r_own];
`else
  assign w_rel = 1'b0;
`endif

  assign w_end = (r_state == S_RUN) && (w_last || w_rel);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_gnt_nxt   = r_gnt;
    w_own_nxt   = r_own;
    w_ptr_nxt   = r_ptr;
    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        if (w_found) begin
          w_state_nxt = S_RUN;
          w_gnt_nxt   = {{(NREQ-1){1'b0}}, 1'b1} << w_pick;
          w_own_nxt   = w_pick;
        end
      end
      S_RUN: begin
        if (w_end) begin
          w_state_nxt = S_IDLE;
          w_gnt_nxt   = '0;
          w_cnt_nxt   = '0;
          w_ptr_nxt   = r_own;
        end else begin
          w_cnt_nxt = r_cnt + CBITS'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_gnt_nxt   = '0;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Reset pointer at NREQ-1 so requester 0 wins the first tie
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_gnt   <= '0;
      r_own   <= '0;
      r_ptr   <= PW'(NREQ - 1);
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_gnt   <= w_gnt_nxt;
      r_own   <= w_own_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

  assign arb.gnt    = r_gnt;
  assign arb.busy   = (r_state == S_RUN);
  assign arb.gray_c = r_cnt ^ (r_cnt >> 1);
  assign arb.sig    = (r_state == S_RUN) && (r_cnt == '0);
  assign arb.done   = w_end;
endmodule

// File: doc/gray_window_arbiter.md
# gray_window_arbiter

Round-robin arbiter that time-shares one Gray-coded window counter among `NREQ` requesters. Each grant owns the counter for a window of `WIN` cycles. The counter restarts at zero on every grant and is published in Gray code, with a start pulse and an end pulse. The block sits in front of the Gray counter datapath and sequences its use. It is sized for safety (one-hot grant) and liveness (every held request is eventually served) checks.

## Interface
Parameters:
- `NREQ`, 4, number of requesters (2..16)
- `CBITS`, 11, counter width
- `WIN`, 16, window length in cycles (1..2**CBITS)

Ports:
- `clk`  input  1  clock
- `rst`  input  1  reset, asynchronous, active-high
- `req`  input  NREQ  request per requester, level-sensitive
- `gnt`  output  NREQ  registered one-hot grant; all-zero when idle
- `busy`  output  1  high while a window is running (`gnt != 0`)
- `gray_c`  output  CBITS  Gray code of the window count: `cnt ^ (cnt >> 1)`
- `sig`  output  1  window-start pulse: busy and `cnt == 0`
- `done`  output  1  window-end pulse: last cycle of the window

## Operation
- Internal state: `state` (IDLE, RUN), `cnt[CBITS-1:0]`, `ptr` (index of the last owner).
- IDLE:
  - `gnt = 0` and `cnt = 0`.
  - If `req != 0`, pick the first set bit searching circularly from `ptr+1`.
  - Register that grant, go to RUN, and set `cnt` to 0.
- RUN:
  - `cnt` increments by 1 each cycle.
  - When `cnt == WIN-1`, `done` pulses; the next cycle returns to IDLE with `gnt = 0` and `ptr` set to the owner.
- Arbitration happens only in IDLE, so there is always at least one all-zero `gnt` cycle between windows.
- `req` changes of non-owners during RUN are ignored.
- `gnt` is never more than one-hot. A requester holding `req` high is granted within `NREQ` windows (no starvation).
- `cnt` never wraps inside a window because `WIN <= 2**CBITS`. With `WIN == 1`, `sig` and `done` are asserted in the same cycle.
- `gray_c` is combinational from the registered `cnt`; consecutive values differ in exactly one bit.

## Timing
- Reset values:
  - `gnt = 0`, `busy = 0`, `gray_c = 0`, `sig = 0`, `done = 0`
  - `state = IDLE`, `cnt = 0`, `ptr = NREQ-1`, so requester 0 wins first on a tie
- Reset mid-window aborts immediately and asynchronously. No `done` is issued for the aborted window.
- Latency from `req` sampled high in IDLE to `gnt` high is 1 cycle.
- `sig` is asserted in the first grant cycle.
- `done` is asserted `WIN-1` cycles after `sig`. `gnt` drops the cycle after `done`.
- Fastest re-grant is one IDLE cycle after `gnt` drops, giving a window period of `WIN+1` cycles.
- A simultaneous `done` and new requests are resolved in the following IDLE cycle.

## Configuration
- Macro: `GRAY_WIN_EARLY_RELEASE_EN`.
- Defined: in RUN, if `req[owner]` is sampled low:
  - `done` pulses that cycle, regardless of `cnt`.
  - The next cycle is IDLE, with `ptr` updated to the owner as usual.
- Undefined: the owner's `req` is ignored during RUN, and every window runs the full `WIN` cycles.

## Test plan
Use `NREQ=4` and `WIN=4` throughout.
- Reset check: assert `rst` with random `req`. Expect `gnt=0`, `busy=0`, `gray_c=0`, `sig=0`, `done=0` in every cycle while reset is high.
- Single requester: hold `req=4'b0100`.
  - `gnt=4'b0100` one cycle later.
  - `gray_c` sequence is 0, 1, 3, 2.
  - `sig` on the first grant cycle, `done` on the fourth.
  - `gnt=0` for 1 cycle, then re-grant.
- All requesting: hold `req=4'b1111`. Grant order is 0, 1, 2, 3, 0, each window 4 cycles with a 1-cycle gap between windows.
- Late arrival: `req[3]` rises during requester 1's window while `req[0]` is held. Next grants are 3, then 0 (circular from `ptr=1`).
- Reset mid-window: assert `rst` at `cnt=2` of requester 2's window.
  - `gnt` clears at once and no `done` is issued.
  - After release, with `req=4'b0101`, requester 0 is granted.
- Early release: `req[1]` drops at `cnt=1`.
  - With `GRAY_WIN_EARLY_RELEASE_EN`: `done` in that cycle, `gnt=0` in the next.
  - Without it: the window runs to `cnt=3`.
